// File: rtl/user_press_counter.sv
// rtl/user_press_counter.sv - button synchroniser, debouncer and press counter
// Counts debounced press edges inside a start/stop round window.
module user_press_counter #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int COUNT_WIDTH     = 8
) (
  input  logic                   Clk100M,
  input  logic                   Reset,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   button,
  output logic [COUNT_WIDTH-1:0] userCount,
  output logic                   counting,
  output logic                   pressPulse,
  output logic                   saturated
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0]        DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

  typedef enum logic {
    IDLE     = 1'b0,
    COUNTING = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   btn_s;
  logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
  logic                   level_q, level_d;
  logic                   level_dly_q;
  logic                   rise;
  logic                   press_q;
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], button};
  assign btn_s  = sync_q[SYNC_STAGES-1];

  // The level only moves after btn_s has disagreed with it for DEBOUNCE_CYCLES edges.
  always_comb begin
    db_cnt_d = '0;
    level_d  = level_q;
    if (btn_s != level_q) begin
      if (db_cnt_q == DB_LAST) begin
        level_d = btn_s;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  assign rise = level_q & ~level_dly_q;

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = COUNTING;
    end else if (state_q == COUNTING && stop) begin
      state_d = IDLE;
    end
  end

  // start clears even when a press lands on the same edge; a press on the stop edge still counts.
  always_comb begin
    count_d = count_q;
    if (start) begin
      count_d = '0;
    end else if (state_q == COUNTING && rise && count_q != COUNT_MAX) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge Clk100M or posedge Reset) begin
    if (Reset) begin
      sync_q      <= '0;
      db_cnt_q    <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      press_q     <= 1'b0;
      count_q     <= '0;
      state_q     <= IDLE;
    end else begin
      sync_q      <= sync_d;
      db_cnt_q    <= db_cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_q;
      press_q     <= rise;
      count_q     <= count_d;
      state_q     <= state_d;
    end
  end

  assign userCount  = count_q;
  assign counting   = (state_q == COUNTING);
  assign pressPulse = press_q;
  assign saturated  = (count_q == COUNT_MAX);

endmodule

// File: tb/tb_user_press_counter.sv
// tb/tb_user_press_counter.sv - directed self-checking bench for user_press_counter
module tb_user_press_counter;

  logic       Clk100M = 1'b0;
  logic       Reset   = 1'b1;
  logic       start   = 1'b0;
  logic       stop    = 1'b0;
  logic       button  = 1'b0;
  logic [7:0] userCount;
  logic       counting;
  logic       pressPulse;
  logic       saturated;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int p0;
  logic [7:0] seen [1:8];

  user_press_counter #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .COUNT_WIDTH    (8)
  ) dut (
    .Clk100M   (Clk100M),
    .Reset     (Reset),
    .start     (start),
    .stop      (stop),
    .button    (button),
    .userCount (userCount),
    .counting  (counting),
    .pressPulse(pressPulse),
    .saturated (saturated)
  );

  always #5 Clk100M = ~Clk100M;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk100M);
    #1;
    if (pressPulse) pulses++;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  // Clean press: held long enough to be accepted, released long enough to settle low.
  task automatic press();
    button = 1'b1; repeat (12) tick();
    button = 1'b0; repeat (8) tick();
  endtask

  // Press whose pulse edge (7th edge) coincides with start (sel=0) or stop (sel=1).
  task automatic press_on_edge(input bit sel);
    button = 1'b1;
    repeat (6) tick();
    if (sel) stop = 1'b1; else start = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check(sel ? "pulse_on_stop" : "pulse_on_start", pressPulse, 1);
    repeat (5) tick();
    button = 1'b0; repeat (8) tick();
  endtask

  initial begin
    repeat (3) tick();
    check("rst_count", userCount, 0);
    check("rst_counting", counting, 0);
    check("rst_pulse", pressPulse, 0);
    check("rst_sat", saturated, 0);
    Reset = 1'b0;
    tick();
    pulse_start();
    check("start_counting", counting, 1);

    // Latency: pulse 7 edges after the first edge that samples the high level.
    p0 = pulses;
    button = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      seen[i] = {6'd0, pressPulse, 1'b0} | {7'd0, 1'b0};
      if (i == 7) check("lat_count", userCount, 1);
    end
    check("lat_edge6", seen[6], 0);
    check("lat_edge7", seen[7], 2);
    check("lat_edge8", seen[8], 0);
    repeat (12) tick();
    button = 1'b0; repeat (10) tick();
    check("held_one_press", pulses - p0, 1);
    check("held_counting", counting, 1);

    // Glitch shorter than the debounce window.
    p0 = pulses;
    button = 1'b1; repeat (3) tick();
    button = 1'b0; repeat (10) tick();
    check("glitch_pulses", pulses - p0, 0);
    check("glitch_count", userCount, 1);

    // Window: 5 in, 2 out, restart.
    pulse_start();
    check("restart_clear", userCount, 0);
    repeat (5) press();
    check("five_presses", userCount, 5);
    pulse_stop();
    check("stop_counting", counting, 0);
    check("stop_hold", userCount, 5);
    p0 = pulses;
    repeat (2) press();
    check("out_window_pulses", pulses - p0, 2);
    check("out_window_hold", userCount, 5);
    pulse_start();
    check("second_start", userCount, 0);
    check("second_counting", counting, 1);

    // start and stop together while IDLE; press on start edge; press on stop edge.
    pulse_stop();
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    check("both_counting", counting, 1);
    check("both_count", userCount, 0);
    press();
    check("pre_start_press", userCount, 1);
    press_on_edge(1'b0);
    check("press_on_start", userCount, 0);
    press_on_edge(1'b1);
    check("press_on_stop", userCount, 1);
    check("press_on_stop_idle", counting, 0);

    // Saturation.
    pulse_start();
    repeat (254) press();
    check("count_254", userCount, 254);
    check("sat_254", saturated, 0);
    repeat (6) press();
    check("count_sat", userCount, 255);
    check("sat_high", saturated, 1);
    pulse_start();
    check("sat_clear_count", userCount, 0);
    check("sat_clear_flag", saturated, 0);

    // Reset mid-debounce.
    repeat (3) press();
    check("pre_reset_count", userCount, 3);
    button = 1'b1;
    repeat (3) tick();
    Reset = 1'b1;
    #1;
    check("async_count", userCount, 0);
    check("async_counting", counting, 0);
    check("async_sat", saturated, 0);
    check("async_pulse", pressPulse, 0);
    repeat (2) tick();
    Reset = 1'b0;
    p0 = pulses;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 6) check("post_reset_edge6", pulses - p0, 0);
    end
    check("post_reset_press", pulses - p0, 1);
    check("post_reset_count", userCount, 0);
    check("post_reset_idle", counting, 0);
    button = 1'b0;
    repeat (10) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
